// File: rtl/pc_control_if.sv
// Bundle of control inputs and fetch-side outputs between the PC stage and its neighbours.
interface pc_control_if #(
    parameter int unsigned B = 32
);
    logic         start;
    logic         step_mode;
    logic         step;
    logic         stall;
    logic         branch_taken;
    logic [B-1:0] branch_target;
    logic         jump;
    logic [B-1:0] jump_target;
    logic [B-1:0] instruction;
    logic [B-1:0] pc;
    logic [B-1:0] pc_plus4;
    logic         fetch_valid;
    logic         halted;
    logic [B-1:0] fetch_count;

    modport master (
        input  start, step_mode, step, stall, branch_taken, branch_target,
               jump, jump_target, instruction,
        output pc, pc_plus4, fetch_valid, halted, fetch_count
    );

    modport slave (
        output start, step_mode, step, stall, branch_taken, branch_target,
               jump, jump_target, instruction,
        input  pc, pc_plus4, fetch_valid, halted, fetch_count
    );
endinterface

// File: rtl/pc_control.sv
// Program-counter stage: next-PC selection, stall handling and run/step/halt sequencing.
module pc_control #(
    parameter int unsigned    B          = 32,
    parameter logic [B-1:0]   RESET_PC   = '0,
    parameter logic [B-1:0]   HALT_INSTR = '1
) (
    input  logic          clk,
    input  logic          reset,
    pc_control_if.master  bus
);
    localparam int unsigned ALIGN_W = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] STEP   = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [B-1:0] pc_q;
    logic [B-1:0] pc_nxt;
    logic [B-1:0] count_q;
    logic         halted_q;
    logic         active;
    logic         fetch_ok;
    logic         halt_hit;
    logic [B-1:0] seq_pc;

    assign seq_pc = pc_q + B'(4);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, next PC and fetch qualification
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        fetch_ok  = 1'b0;
        halt_hit  = 1'b0;
        active    = (state == RUN) || ((state == STEP) && bus.step);

        if (active) begin
            if (bus.branch_taken) begin
                pc_nxt = {bus.branch_target[B-1:ALIGN_W], ALIGN_W'(0)};
            end else if (bus.jump) begin
                pc_nxt = {bus.jump_target[B-1:ALIGN_W], ALIGN_W'(0)};
            end else if (bus.stall) begin
                pc_nxt = pc_q;
            end else if (bus.instruction == HALT_INSTR) begin
                halt_hit = 1'b1;
            end else begin
                pc_nxt   = seq_pc;
                fetch_ok = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (bus.start) state_nxt = bus.step_mode ? STEP : RUN;
            end
            RUN: begin
                if (halt_hit)           state_nxt = HALTED;
                else if (bus.step_mode) state_nxt = STEP;
            end
            STEP: begin
                if (halt_hit)            state_nxt = HALTED;
                else if (!bus.step_mode) state_nxt = RUN;
            end
            default: state_nxt = HALTED;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_nxt;
            halted_q <= (state_nxt == HALTED);
            if (fetch_ok) count_q <= count_q + B'(1);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = seq_pc;
    assign bus.fetch_valid = fetch_ok;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_pc_control.sv
// Randomised scoreboard bench for pc_control against a behavioural fetch model.
module tb_pc_control;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        step_mode;
        logic        step;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic [31:0] instr;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        fv;
        logic        halted;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   passed;
    int   cyc;
    exp_t sb[$];

    // Reference model state: started, halted, step-mode selection and counters
    logic        m_started;
    logic        m_halted;
    logic        m_stepping;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    pc_control_if #(.B(32)) bus ();

    pc_control #(.B(32), .RESET_PC(32'h0), .HALT_INSTR(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    function automatic stim_t nop();
        stim_t s;
        s.rst_n = 1'b1; s.start = 1'b0; s.step_mode = 1'b0; s.step = 1'b0; s.stall = 1'b0;
        s.br = 1'b0; s.bt = '0; s.jp = 1'b0; s.jt = '0; s.instr = NOP;
        return s;
    endfunction

    // Expected outputs for this cycle, then advance the model across the coming edge
    task automatic model(input stim_t s, output exp_t e);
        logic running;
        e.fv = 1'b0;
        if (!s.rst_n) begin
            m_started = 1'b0; m_halted = 1'b0; m_stepping = 1'b0;
            m_pc = 32'h0; m_cnt = 32'h0;
            e.pc = 32'h0; e.pc4 = 32'h4; e.cnt = 32'h0; e.halted = 1'b0;
            return;
        end
        e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.cnt = m_cnt; e.halted = m_halted;
        running = m_started && !m_halted;
        if (!m_started) begin
            if (s.start) begin
                m_started  = 1'b1;
                m_stepping = s.step_mode;
            end
        end else if (running) begin
            if (!m_stepping || s.step) begin
                if (s.br)                 m_pc = s.bt & ~32'd3;
                else if (s.jp)            m_pc = s.jt & ~32'd3;
                else if (s.stall)         m_pc = m_pc;
                else if (s.instr == HALT) m_halted = 1'b1;
                else begin
                    e.fv  = 1'b1;
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end
            end
            m_stepping = s.step_mode;
        end
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset             = s.rst_n;
        bus.start         = s.start;
        bus.step_mode     = s.step_mode;
        bus.step          = s.step;
        bus.stall         = s.stall;
        bus.branch_taken  = s.br;
        bus.branch_target = s.bt;
        bus.jump          = s.jp;
        bus.jump_target   = s.jt;
        bus.instruction   = s.instr;
        model(s, e);
        sb.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if (bus.pc === e.pc && bus.pc_plus4 === e.pc4 && bus.fetch_valid === e.fv &&
                    bus.halted === e.halted && bus.fetch_count === e.cnt) begin
                    passed++;
                end else begin
                    $display("FAIL cycle%0d: pc=%h/%h pc4=%h/%h fv=%b/%b halted=%b/%b cnt=%0d/%0d (actual/required)",
                             cyc, bus.pc, e.pc, bus.pc_plus4, e.pc4, bus.fetch_valid, e.fv,
                             bus.halted, e.halted, bus.fetch_count, e.cnt);
                end
                cyc++;
            end
        end
    end

    initial begin
        stim_t s;
        logic  sm;
        int    halt_wait;
        total = 0; passed = 0;
        reset = 1'b0;
        s = nop();
        bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0; bus.stall = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = '0; bus.jump = 1'b0; bus.jump_target = '0;
        bus.instruction = NOP;

        s = nop(); s.rst_n = 1'b0;
        drive(s); drive(s);
        #3 check("reset_pc", bus.pc, 32'h0);
        check("reset_cnt", bus.fetch_count, 32'h0);

        // Free-run from 0 with NOPs
        s = nop(); s.start = 1'b1; drive(s);
        s = nop(); drive(s); drive(s); drive(s);
        drive(s);
        #3 check("t1_pc", bus.pc, 32'hC);
        check("t1_cnt", bus.fetch_count, 32'd3);

        // Two stall cycles at 0x10
        s = nop(); s.stall = 1'b1; drive(s);
        #3 check("t2_pc_hold", bus.pc, 32'h10);
        check("t2_fv", 32'(bus.fetch_valid), 32'h0);
        drive(s);
        s = nop(); drive(s);
        s = nop(); s.jp = 1'b1; s.jt = 32'h20; drive(s);
        #3 check("t2_resume", bus.pc, 32'h14);

        // Branch beats jump, stall and halt
        s = nop(); s.br = 1'b1; s.bt = 32'h103; s.jp = 1'b1; s.jt = 32'h200; s.stall = 1'b1;
        s.instr = HALT; drive(s);
        #3 check("t3_fv", 32'(bus.fetch_valid), 32'h0);
        s = nop(); s.jp = 1'b1; s.jt = 32'h41; drive(s);
        #3 check("t3_pc", bus.pc, 32'h100);

        // Halt at 0x40, then poke everything
        s = nop(); s.instr = HALT; drive(s);
        s = nop(); s.start = 1'b1; s.step = 1'b1; s.jp = 1'b1; s.jt = 32'h80; drive(s);
        #3 check("t4_halted", 32'(bus.halted), 32'h1);
        drive(s);
        #3 check("t4_pc", bus.pc, 32'h40);

        // Single step
        s = nop(); s.rst_n = 1'b0; drive(s);
        s = nop(); s.start = 1'b1; s.step_mode = 1'b1; drive(s);
        s = nop(); s.step_mode = 1'b1;
        repeat (5) drive(s);
        #3 check("t5_frozen", bus.pc, 32'h0);
        s.step = 1'b1; drive(s); s.step = 1'b0; drive(s); s.step = 1'b1; drive(s); s.step = 1'b0;
        drive(s);
        #3 check("t5_two_steps", bus.pc, 32'h8);
        s = nop(); drive(s); drive(s); drive(s);
        #3 check("t5_free_run", bus.pc, 32'hC);

        // Wrap past the top of the address space
        s = nop(); s.jp = 1'b1; s.jt = 32'hFFFF_FFFB; drive(s);
        s = nop(); drive(s); drive(s); drive(s);
        #3 check("wrap_pc", bus.pc, 32'h0);

        // Reset between edges
        s = nop(); s.rst_n = 1'b0; drive(s);
        #3 check("t6_pc", bus.pc, 32'h0);
        check("t6_cnt", bus.fetch_count, 32'h0);
        check("t6_halted", 32'(bus.halted), 32'h0);

        // Random traffic
        sm = 1'b0; halt_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            s = nop();
            if ($urandom_range(0, 40) == 0) sm = ~sm;
            s.step_mode = sm;
            s.start     = ($urandom_range(0, 2) == 0);
            s.step      = ($urandom_range(0, 2) == 0);
            s.stall     = ($urandom_range(0, 5) == 0);
            s.br        = ($urandom_range(0, 9) == 0);
            s.jp        = ($urandom_range(0, 9) == 0);
            s.bt        = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom);
            s.jt        = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom);
            s.instr     = ($urandom_range(0, 40) == 0) ? HALT : 32'($urandom);
            if (s.instr == HALT && $urandom_range(0, 1) == 0) s.instr = HALT;
            else if (s.instr == HALT) s.instr = NOP;
            halt_wait = m_halted ? halt_wait + 1 : 0;
            if (halt_wait > 4 || $urandom_range(0, 300) == 0) s.rst_n = 1'b0;
            drive(s);
        end

        @(negedge clk);
        @(negedge clk);
        #3;
        if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
